rv_retire_trace: RTL and testbench

Synthesizable retirement monitor for the pipelined RV core; generalises the single-lane commit log to NUM_RET retire lanes per cycle. Classifies each retired instruction (REG/LOAD/STORE/NONE), masks store data by access width, buffers entries in a multi-push FIFO and streams them out over valid/ready. Keeps instruction and cycle counters, detects the end-of-program marker (instr == 0), and drains before reporting done.

---
 rtl/rv_retire_trace_pkg.sv | 76 +++++++
 rtl/rv_retire_trace_if.sv | 34 +++
 rtl/rv_trace_fifo.sv | 50 +++++
 rtl/rv_retire_trace.sv | 163 ++++++++++++++++
 tb/tb_rv_retire_trace.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_retire_trace_pkg.sv
// Shared types for the retirement trace monitor: entry layout, kind/state enums, lane classifier.
// Entry gains a cycle stamp when RV_TRACE_TIMESTAMP_EN is defined.
package rv_retire_trace_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 64;

    localparam logic [6:0] OpcodeBranch = 7'b1100011;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        REG   = 2'd1,
        LOAD  = 2'd2,
        STORE = 2'd3
    } trace_kind_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } trace_state_e;

    typedef struct packed {
`ifdef RV_TRACE_TIMESTAMP_EN
        logic [CNT_W-1:0] cycle;
`endif
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        trace_kind_e     kind;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_data;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_data;
    } trace_entry_t;

    function automatic trace_entry_t build_entry(
        input logic [XLEN-1:0] pc,
        input logic [31:0]     instr,
        input logic [4:0]      rd,
        input logic [XLEN-1:0] rd_data,
        input logic            mem_wrt,
        input logic            mem_read,
        input logic [XLEN-1:0] mem_addr,
        input logic [XLEN-1:0] mem_data
    );
        trace_entry_t e;
        logic         is32;
        is32       = (instr[1:0] == 2'b11);
        e          = '0;
        e.pc       = pc;
        e.instr    = is32 ? instr : {16'h0000, instr[15:0]};
        e.rd_addr  = rd;
        e.rd_data  = rd_data;
        e.mem_addr = mem_addr;
        e.mem_data = mem_data;
        if (mem_wrt) begin
            e.kind = STORE;
            // Byte/half stores only carry the low lanes; compressed stores are always word-sized.
            if (is32 && instr[14:12] == 3'b000) begin
                e.mem_data = {{(XLEN-8){1'b0}}, mem_data[7:0]};
            end else if (is32 && instr[14:12] == 3'b001) begin
                e.mem_data = {{(XLEN-16){1'b0}}, mem_data[15:0]};
            end
        end else if (mem_read) begin
            e.kind = LOAD;
        end else if (rd == 5'd0 || (is32 && instr[6:0] == OpcodeBranch)) begin
            e.kind    = NONE;
            e.rd_data = '0;
        end else begin
            e.kind = REG;
        end
        return e;
    endfunction

endpackage

// File: rtl/rv_retire_trace_if.sv
// Retire-lane bus from the core plus the trace stream towards the consumer.
// master = core/consumer side, slave = trace monitor.
interface rv_retire_trace_if #(
    parameter int NUM_RET = 2
);
    import rv_retire_trace_pkg::*;

    logic [NUM_RET-1:0]      ret_valid_i;
    logic [NUM_RET*XLEN-1:0] ret_pc_i;
    logic [NUM_RET*32-1:0]   ret_instr_i;
    logic [NUM_RET*5-1:0]    ret_rd_addr_i;
    logic [NUM_RET*XLEN-1:0] ret_rd_data_i;
    logic [NUM_RET-1:0]      ret_mem_wrt_i;
    logic [NUM_RET-1:0]      ret_mem_read_i;
    logic [NUM_RET*XLEN-1:0] ret_mem_addr_i;
    logic [NUM_RET*XLEN-1:0] ret_mem_data_i;
    logic                    stall_req_o;
    logic                    trc_valid_o;
    logic                    trc_ready_i;
    trace_entry_t            trc_entry_o;

    modport master (
        output ret_valid_i, ret_pc_i, ret_instr_i, ret_rd_addr_i, ret_rd_data_i,
               ret_mem_wrt_i, ret_mem_read_i, ret_mem_addr_i, ret_mem_data_i, trc_ready_i,
        input  stall_req_o, trc_valid_o, trc_entry_o
    );

    modport slave (
        input  ret_valid_i, ret_pc_i, ret_instr_i, ret_rd_addr_i, ret_rd_data_i,
               ret_mem_wrt_i, ret_mem_read_i, ret_mem_addr_i, ret_mem_data_i, trc_ready_i,
        output stall_req_o, trc_valid_o, trc_entry_o
    );

endinterface

// File: rtl/rv_trace_fifo.sv
// Multi-push (up to NUM_RET per cycle, lane-packed), single-pop FIFO exposing used/free counts.
// Latency: pushed entry visible at head the next cycle.
// Backpressure: caller must never push more than free (+1 when popping); no internal guard.
module rv_trace_fifo #(
    parameter int  W       = 8,
    parameter int  NUM_RET = 2,
    parameter int  DEPTH   = 16,
    localparam int AW      = $clog2(DEPTH),
    localparam int PW      = $clog2(NUM_RET + 1)
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [PW-1:0]               push_cnt,
    input  logic [NUM_RET-1:0][W-1:0]   push_dat,
    input  logic                        pop,
    output logic [W-1:0]                head_dat,
    output logic                        head_vld,
    output logic [AW:0]                 used,
    output logic [AW:0]                 free
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_RET; i++) begin
            if (i < int'(push_cnt)) begin
                mem[wptr[AW-1:0] + AW'(i)] <= push_dat[i];
            end
        end
    end

    // Extra pointer bit disambiguates full from empty; both pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + (AW+1)'(push_cnt);
            rptr <= rptr + {{AW{1'b0}}, pop};
        end
    end

    assign used     = wptr - rptr;
    assign free     = (AW+1)'(DEPTH) - used;
    assign head_vld = (used != '0);
    assign head_dat = mem[rptr[AW-1:0]];

endmodule

// File: rtl/rv_retire_trace.sv
// Retirement monitor: classifies NUM_RET retire lanes, packs them into a trace FIFO, streams them out.
// Latency: entry retired in cycle N appears on trc_entry_o at N+1 earliest. Optional RV_TRACE_TIMESTAMP_EN.
// Backpressure: registered stall_req_o when fewer than NUM_RET slots remain; excess lanes dropped and counted.
module rv_retire_trace #(
    parameter int XLEN    = rv_retire_trace_pkg::XLEN,
    parameter int NUM_RET = 2,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = rv_retire_trace_pkg::CNT_W
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             enable_i,
    rv_retire_trace_if.slave bus,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o,
    output logic             overflow_o,
    output logic             done_o
);
    import rv_retire_trace_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(NUM_RET + 1);
    localparam int EW = $bits(trace_entry_t);

    trace_state_e                state_q, state_d;
    logic                        run;
    logic                        halt_seen;
    logic                        halt_hit;
    logic [NUM_RET-1:0]          acc_vec;
    trace_entry_t                lane_entry [NUM_RET];
    logic [NUM_RET-1:0][EW-1:0]  push_dat;
    logic [EW-1:0]               head_dat;
    logic                        head_vld;
    logic                        pop;
    logic [AW:0]                 fifo_used;
    logic [AW:0]                 fifo_free;
    logic                        stall_q;
    int                          acc_n, push_n, drop_n, free_eff, free_after, pos;

    // Lanes at and above the first halt marker are never logged.
    always_comb begin
        halt_seen = 1'b0;
        acc_vec   = '0;
        for (int i = 0; i < NUM_RET; i++) begin
            if (bus.ret_valid_i[i] && bus.ret_instr_i[i*32 +: 32] == 32'd0) begin
                halt_seen = 1'b1;
            end
            acc_vec[i] = run && bus.ret_valid_i[i] && !halt_seen;
        end
        halt_hit = run && halt_seen;
    end

    always_comb begin
        for (int i = 0; i < NUM_RET; i++) begin
            lane_entry[i] = build_entry(bus.ret_pc_i[i*XLEN +: XLEN],
                                        bus.ret_instr_i[i*32 +: 32],
                                        bus.ret_rd_addr_i[i*5 +: 5],
                                        bus.ret_rd_data_i[i*XLEN +: XLEN],
                                        bus.ret_mem_wrt_i[i],
                                        bus.ret_mem_read_i[i],
                                        bus.ret_mem_addr_i[i*XLEN +: XLEN],
                                        bus.ret_mem_data_i[i*XLEN +: XLEN]);
`ifdef RV_TRACE_TIMESTAMP_EN
            lane_entry[i].cycle = cycle_cnt_o;
`endif
        end
    end

    // Compact accepted lanes into consecutive push slots, oldest first.
    always_comb begin
        push_dat = '0;
        acc_n    = 0;
        pos      = 0;
        for (int i = 0; i < NUM_RET; i++) begin
            pos = 0;
            for (int j = 0; j < i; j++) begin
                pos = pos + int'(acc_vec[j]);
            end
            for (int s = 0; s < NUM_RET; s++) begin
                if (acc_vec[i] && pos == s) begin
                    push_dat[s] = lane_entry[i];
                end
            end
            acc_n = acc_n + int'(acc_vec[i]);
        end
    end

    assign pop = head_vld & bus.trc_ready_i;

    always_comb begin
        free_eff   = int'(fifo_free) + int'(pop);
        push_n     = (acc_n > free_eff) ? free_eff : acc_n;
        drop_n     = acc_n - push_n;
        free_after = free_eff - push_n;
    end

    rv_trace_fifo #(
        .W       (EW),
        .NUM_RET (NUM_RET),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .push_cnt (PW'(push_n)),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .head_vld (head_vld),
        .used     (fifo_used),
        .free     (fifo_free)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DRAIN completes on the cycle the last entry pops, so done follows that pop directly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable_i) state_d = RUN;
            RUN:     if (halt_hit) state_d = DRAIN;
            DRAIN:   if (int'(fifo_used) - int'(pop) == 0) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        run    = (state_q == RUN);
        done_o = (state_q == DONE);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            instr_cnt_o <= '0;
            cycle_cnt_o <= '0;
            drop_cnt_o  <= '0;
            overflow_o  <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            instr_cnt_o <= instr_cnt_o + CNT_W'(push_n);
            drop_cnt_o  <= drop_cnt_o + CNT_W'(drop_n);
            if (drop_n != 0) begin
                overflow_o <= 1'b1;
            end
            if (run) begin
                cycle_cnt_o <= cycle_cnt_o + 1'b1;
            end
            stall_q <= (free_after < NUM_RET);
        end
    end

    assign bus.stall_req_o = stall_q;
    assign bus.trc_valid_o = head_vld;
    assign bus.trc_entry_o = head_dat;

endmodule

// File: tb/tb_rv_retire_trace.sv
// Directed bench for rv_retire_trace with NUM_RET=2, DEPTH=4.
module tb_rv_retire_trace;
    import rv_retire_trace_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic [63:0] instr_cnt, cycle_cnt, drop_cnt;
    logic        overflow, done;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    rv_retire_trace_if #(.NUM_RET(2)) bus ();

    rv_retire_trace #(.XLEN(32), .NUM_RET(2), .DEPTH(4), .CNT_W(64)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .enable_i    (enable),
        .bus         (bus.slave),
        .instr_cnt_o (instr_cnt),
        .cycle_cnt_o (cycle_cnt),
        .drop_cnt_o  (drop_cnt),
        .overflow_o  (overflow),
        .done_o      (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        bus.ret_valid_i    = '0;
        bus.ret_pc_i       = '0;
        bus.ret_instr_i    = '0;
        bus.ret_rd_addr_i  = '0;
        bus.ret_rd_data_i  = '0;
        bus.ret_mem_wrt_i  = '0;
        bus.ret_mem_read_i = '0;
        bus.ret_mem_addr_i = '0;
        bus.ret_mem_data_i = '0;
    endtask

    task automatic set_lane(input int l, input logic [31:0] pc, input logic [31:0] instr,
                            input logic [4:0] rd, input logic [31:0] rdd, input logic wrt,
                            input logic rdm, input logic [31:0] addr, input logic [31:0] data);
        bus.ret_valid_i[l]            = 1'b1;
        bus.ret_pc_i[l*32 +: 32]      = pc;
        bus.ret_instr_i[l*32 +: 32]   = instr;
        bus.ret_rd_addr_i[l*5 +: 5]   = rd;
        bus.ret_rd_data_i[l*32 +: 32] = rdd;
        bus.ret_mem_wrt_i[l]          = wrt;
        bus.ret_mem_read_i[l]         = rdm;
        bus.ret_mem_addr_i[l*32 +: 32] = addr;
        bus.ret_mem_data_i[l*32 +: 32] = data;
    endtask

    task automatic do_reset();
        rstn   = 1'b0;
        enable = 1'b0;
        clear_lanes();
        bus.trc_ready_i = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic start();
        enable = 1'b1;
        step();
        enable = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (bus.trc_valid_o !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", bus.trc_valid_o); end
        tests++; if (bus.stall_req_o !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b want 0", bus.stall_req_o); end
        tests++; if (instr_cnt !== 64'd0) begin fails++; $display("FAIL rst_instr_cnt: got %0d want 0", instr_cnt); end
        tests++; if (cycle_cnt !== 64'd0) begin fails++; $display("FAIL rst_cycle_cnt: got %0d want 0", cycle_cnt); end
        tests++; if (drop_cnt !== 64'd0) begin fails++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", done); end
        // Retire traffic while IDLE must be ignored.
        set_lane(0, 32'h10, 32'h02A00293, 5'd5, 32'h2A, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        clear_lanes();
        step();
        tests++; if (instr_cnt !== 64'd0) begin fails++; $display("FAIL idle_ignore_cnt: got %0d want 0", instr_cnt); end
        tests++; if (bus.trc_valid_o !== 1'b0) begin fails++; $display("FAIL idle_ignore_valid: got %b want 0", bus.trc_valid_o); end
    endtask

    task automatic test_reg_none();
        trace_entry_t e;
        do_reset();
        start();
        set_lane(0, 32'h1000, 32'h02A00293, 5'd5, 32'h0000002A, 1'b0, 1'b0, 32'h0, 32'h0);
        set_lane(1, 32'h1004, 32'h00000063, 5'd0, 32'h00001234, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        clear_lanes();
        e = bus.trc_entry_o;
        tests++; if (bus.trc_valid_o !== 1'b1) begin fails++; $display("FAIL reg_valid: got %b want 1", bus.trc_valid_o); end
        tests++; if (e.pc !== 32'h1000) begin fails++; $display("FAIL reg_pc: got %h want 00001000", e.pc); end
        tests++; if (e.kind !== REG) begin fails++; $display("FAIL reg_kind: got %0d want 1", e.kind); end
        tests++; if (e.rd_addr !== 5'd5) begin fails++; $display("FAIL reg_rd: got %0d want 5", e.rd_addr); end
        tests++; if (e.rd_data !== 32'h0000002A) begin fails++; $display("FAIL reg_data: got %h want 0000002a", e.rd_data); end
        tests++; if (instr_cnt !== 64'd2) begin fails++; $display("FAIL reg_instr_cnt: got %0d want 2", instr_cnt); end
        tests++; if (cycle_cnt !== 64'd1) begin fails++; $display("FAIL reg_cycle_cnt: got %0d want 1", cycle_cnt); end
        bus.trc_ready_i = 1'b1;
        step();
        e = bus.trc_entry_o;
        tests++; if (e.pc !== 32'h1004) begin fails++; $display("FAIL none_pc: got %h want 00001004", e.pc); end
        tests++; if (e.kind !== NONE) begin fails++; $display("FAIL none_kind: got %0d want 0", e.kind); end
        tests++; if (e.rd_data !== 32'h0) begin fails++; $display("FAIL none_data: got %h want 00000000", e.rd_data); end
        step();
        tests++; if (bus.trc_valid_o !== 1'b0) begin fails++; $display("FAIL none_empty: got %b want 0", bus.trc_valid_o); end
        bus.trc_ready_i = 1'b0;
    endtask

    task automatic test_store_mask();
        trace_entry_t e;
        do_reset();
        start();
        set_lane(0, 32'h2000, 32'h00A10023, 5'd0, 32'h0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF);
        set_lane(1, 32'h2004, 32'h00A11023, 5'd0, 32'h0, 1'b1, 1'b0, 32'h104, 32'hDEADBEEF);
        step();
        clear_lanes();
        set_lane(0, 32'h2008, 32'hABCDC10C, 5'd0, 32'h0, 1'b1, 1'b0, 32'h108, 32'hDEADBEEF);
        step();
        clear_lanes();
        e = bus.trc_entry_o;
        tests++; if (e.kind !== STORE) begin fails++; $display("FAIL sb_kind: got %0d want 3", e.kind); end
        tests++; if (e.mem_data !== 32'h000000EF) begin fails++; $display("FAIL sb_data: got %h want 000000ef", e.mem_data); end
        bus.trc_ready_i = 1'b1;
        step();
        e = bus.trc_entry_o;
        tests++; if (e.mem_data !== 32'h0000BEEF) begin fails++; $display("FAIL sh_data: got %h want 0000beef", e.mem_data); end
        step();
        e = bus.trc_entry_o;
        tests++; if (e.mem_data !== 32'hDEADBEEF) begin fails++; $display("FAIL csw_data: got %h want deadbeef", e.mem_data); end
        tests++; if (e.instr !== 32'h0000C10C) begin fails++; $display("FAIL csw_instr: got %h want 0000c10c", e.instr); end
        tests++; if (e.kind !== STORE) begin fails++; $display("FAIL csw_kind: got %0d want 3", e.kind); end
        step();
        bus.trc_ready_i = 1'b0;
        tests++; if (instr_cnt !== 64'd3) begin fails++; $display("FAIL store_instr_cnt: got %0d want 3", instr_cnt); end
    endtask

    task automatic test_halt();
        trace_entry_t e;
        do_reset();
        start();
        set_lane(0, 32'h3000, 32'h00012283, 5'd5, 32'h55, 1'b0, 1'b1, 32'h80, 32'h0);
        set_lane(1, 32'h3004, 32'h00000000, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        clear_lanes();
        e = bus.trc_entry_o;
        tests++; if (instr_cnt !== 64'd1) begin fails++; $display("FAIL halt_instr_cnt: got %0d want 1", instr_cnt); end
        tests++; if (e.kind !== LOAD) begin fails++; $display("FAIL halt_kind: got %0d want 2", e.kind); end
        tests++; if (e.pc !== 32'h3000) begin fails++; $display("FAIL halt_pc: got %h want 00003000", e.pc); end
        tests++; if (cycle_cnt !== 64'd1) begin fails++; $display("FAIL halt_cycle_cnt: got %0d want 1", cycle_cnt); end
        // Retires after the halt land in DRAIN and must be ignored.
        set_lane(0, 32'h3008, 32'h02A00293, 5'd5, 32'h2A, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        clear_lanes();
        step();
        step();
        tests++; if (instr_cnt !== 64'd1) begin fails++; $display("FAIL drain_ignore: got %0d want 1", instr_cnt); end
        tests++; if (cycle_cnt !== 64'd1) begin fails++; $display("FAIL cycle_frozen: got %0d want 1", cycle_cnt); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL done_early: got %b want 0", done); end
        bus.trc_ready_i = 1'b1;
        step();
        bus.trc_ready_i = 1'b0;
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL done_after_pop: got %b want 1", done); end
        tests++; if (bus.trc_valid_o !== 1'b0) begin fails++; $display("FAIL done_empty: got %b want 0", bus.trc_valid_o); end
        step();
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL done_hold: got %b want 1", done); end
    endtask

    task automatic test_overflow();
        do_reset();
        start();
        for (int c = 0; c < 3; c++) begin
            set_lane(0, 32'h100 + 32'(8*c), 32'h02A00293, 5'd5, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0);
            set_lane(1, 32'h104 + 32'(8*c), 32'h02A00293, 5'd5, 32'h2, 1'b0, 1'b0, 32'h0, 32'h0);
            step();
            if (c == 0) begin
                tests++; if (bus.stall_req_o !== 1'b0) begin fails++; $display("FAIL ovf_stall_c0: got %b want 0", bus.stall_req_o); end
                tests++; if (instr_cnt !== 64'd2) begin fails++; $display("FAIL ovf_cnt_c0: got %0d want 2", instr_cnt); end
            end else if (c == 1) begin
                tests++; if (bus.stall_req_o !== 1'b1) begin fails++; $display("FAIL ovf_stall_c1: got %b want 1", bus.stall_req_o); end
                tests++; if (drop_cnt !== 64'd0) begin fails++; $display("FAIL ovf_drop_c1: got %0d want 0", drop_cnt); end
            end
        end
        clear_lanes();
        tests++; if (instr_cnt !== 64'd4) begin fails++; $display("FAIL ovf_instr_cnt: got %0d want 4", instr_cnt); end
        tests++; if (drop_cnt !== 64'd2) begin fails++; $display("FAIL ovf_drop_cnt: got %0d want 2", drop_cnt); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        bus.trc_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tests++; if (bus.trc_entry_o.pc !== 32'h100 + 32'(4*k)) begin fails++; $display("FAIL ovf_order%0d: got %h want %h", k, bus.trc_entry_o.pc, 32'h100 + 32'(4*k)); end
            step();
        end
        bus.trc_ready_i = 1'b0;
        tests++; if (bus.trc_valid_o !== 1'b0) begin fails++; $display("FAIL ovf_empty: got %b want 0", bus.trc_valid_o); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_full_pop_push();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h104; exp_pc[1] = 32'h108; exp_pc[2] = 32'h10C; exp_pc[3] = 32'h200;
        do_reset();
        start();
        for (int c = 0; c < 2; c++) begin
            set_lane(0, 32'h100 + 32'(8*c), 32'h02A00293, 5'd5, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0);
            set_lane(1, 32'h104 + 32'(8*c), 32'h02A00293, 5'd5, 32'h2, 1'b0, 1'b0, 32'h0, 32'h0);
            step();
        end
        clear_lanes();
        set_lane(0, 32'h200, 32'h02A00293, 5'd5, 32'h3, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.trc_ready_i = 1'b1;
        step();
        clear_lanes();
        tests++; if (drop_cnt !== 64'd0) begin fails++; $display("FAIL fpp_drop: got %0d want 0", drop_cnt); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL fpp_overflow: got %b want 0", overflow); end
        tests++; if (instr_cnt !== 64'd5) begin fails++; $display("FAIL fpp_instr_cnt: got %0d want 5", instr_cnt); end
        tests++; if (bus.stall_req_o !== 1'b1) begin fails++; $display("FAIL fpp_stall: got %b want 1", bus.stall_req_o); end
        for (int k = 0; k < 4; k++) begin
            tests++; if (bus.trc_entry_o.pc !== exp_pc[k]) begin fails++; $display("FAIL fpp_order%0d: got %h want %h", k, bus.trc_entry_o.pc, exp_pc[k]); end
            step();
        end
        bus.trc_ready_i = 1'b0;
        tests++; if (bus.trc_valid_o !== 1'b0) begin fails++; $display("FAIL fpp_empty: got %b want 0", bus.trc_valid_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start();
        set_lane(0, 32'h400, 32'h02A00293, 5'd5, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0);
        set_lane(1, 32'h404, 32'h02A00293, 5'd5, 32'h2, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        clear_lanes();
        set_lane(0, 32'h408, 32'h02A00293, 5'd5, 32'h3, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        clear_lanes();
        tests++; if (instr_cnt !== 64'd3) begin fails++; $display("FAIL mid_pre_cnt: got %0d want 3", instr_cnt); end
        rstn = 1'b0;
        step();
        tests++; if (bus.trc_valid_o !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b want 0", bus.trc_valid_o); end
        tests++; if (instr_cnt !== 64'd0) begin fails++; $display("FAIL mid_instr_cnt: got %0d want 0", instr_cnt); end
        tests++; if (cycle_cnt !== 64'd0) begin fails++; $display("FAIL mid_cycle_cnt: got %0d want 0", cycle_cnt); end
        rstn = 1'b1;
        // Back in IDLE: un-enabled retires are not logged.
        set_lane(0, 32'h500, 32'h02A00293, 5'd5, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        clear_lanes();
        tests++; if (instr_cnt !== 64'd0) begin fails++; $display("FAIL mid_idle_cnt: got %0d want 0", instr_cnt); end
        tests++; if (bus.trc_valid_o !== 1'b0) begin fails++; $display("FAIL mid_idle_valid: got %b want 0", bus.trc_valid_o); end
        tests++; if (cycle_cnt !== 64'd0) begin fails++; $display("FAIL mid_idle_cycle: got %0d want 0", cycle_cnt); end
    endtask

    initial begin
        clear_lanes();
        bus.trc_ready_i = 1'b0;
        test_reset();
        test_reg_none();
        test_store_mask();
        test_halt();
        test_overflow();
        test_full_pop_push();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
